// File: rtl/lc3_fetch.sv
// lc3_fetch -- LC-3 instruction fetch stage.
//
// Holds the PC, issues single-word reads to instruction memory (fixed
// read latency MEM_LAT), and presents each fetched word together with
// its next-PC on the decode_in bus (enable_decode, dout, npc_in).
// A fetched word is held while decode stalls; a taken branch redirects
// the PC and abandons any fetch that is still in flight.
//
// Parameters:
//   PC_RESET  PC value loaded on reset (default 16'h3000)
//   MEM_LAT   instruction-memory read latency in cycles, 1..15
//
// Ports:
//   clock          pipeline clock, rising edge
//   reset          asynchronous active-low reset
//   enable_fetch   1 permits new fetch requests
//   stall          decode backpressure, holds the current issue
//   br_taken       1-cycle pulse, redirect PC to taddr
//   taddr[15:0]    branch/jump target
//   imem_rd        instruction-memory read strobe, one cycle per fetch
//   imem_addr      read address, always equal to the PC
//   imem_rdata     read data, valid MEM_LAT cycles after imem_rd
//   enable_decode  valid qualifier for dout/npc_in
//   dout[15:0]     fetched instruction word
//   npc_in[15:0]   address of dout + 1 (mod 2^16)
//
// Optional feature (macro LC3_FETCH_INSTR_COUNT_EN):
//   instr_count[31:0]  number of instructions accepted by decode,
//                      wrapping at 2^32.
module lc3_fetch #(
  parameter logic [15:0] PC_RESET = 16'h3000,
  parameter int unsigned MEM_LAT  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_fetch,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] taddr,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
`ifdef LC3_FETCH_INSTR_COUNT_EN
  output logic [31:0] instr_count,
`endif
  output logic        enable_decode,
  output logic [15:0] dout,
  output logic [15:0] npc_in
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    ISSUE
  } state_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t      r_state;
  logic [15:0] r_pc;
  logic [3:0]  r_lat_cnt;
  logic [15:0] r_dout;
  logic [15:0] r_npc;
  logic        r_imem_rd;
  logic        r_en_dec;
  logic [15:0] w_pc_inc;

  assign w_pc_inc = r_pc + 16'd1;

  // imem_rd and enable_decode are registered: each is set on the edge
  // that enters REQ or ISSUE (or keeps ISSUE under stall), so they are
  // exactly "state == REQ" / "state == ISSUE" without decode glitches.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_pc      <= PC_RESET;
      r_lat_cnt <= '0;
      r_dout    <= '0;
      r_npc     <= '0;
      r_imem_rd <= 1'b0;
      r_en_dec  <= 1'b0;
    end else begin
      r_imem_rd <= 1'b0;
      r_en_dec  <= 1'b0;
      if (br_taken) begin
        // Branch wins over stall and over WAIT completion; any response
        // still in flight is simply never captured.
        r_pc      <= taddr;
        r_lat_cnt <= '0;
        if (enable_fetch) begin
          r_state   <= REQ;
          r_imem_rd <= 1'b1;
        end else begin
          r_state <= IDLE;
        end
      end else begin
        unique case (r_state)
          IDLE: begin
            if (enable_fetch) begin
              r_state   <= REQ;
              r_imem_rd <= 1'b1;
            end
          end
          REQ: begin
            r_lat_cnt <= LAT;
            r_state   <= WAIT;
          end
          WAIT: begin
            r_lat_cnt <= r_lat_cnt - 4'd1;
            if (r_lat_cnt == 4'd1) begin
              r_dout   <= imem_rdata;
              r_npc    <= w_pc_inc;
              r_state  <= ISSUE;
              r_en_dec <= 1'b1;
            end
          end
          ISSUE: begin
            if (stall) begin
              r_en_dec <= 1'b1;
            end else begin
              r_pc <= w_pc_inc;
              if (enable_fetch) begin
                r_state   <= REQ;
                r_imem_rd <= 1'b1;
              end else begin
                r_state <= IDLE;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign imem_rd       = r_imem_rd;
  assign imem_addr     = r_pc;
  assign enable_decode = r_en_dec;
  assign dout          = r_dout;
  assign npc_in        = r_npc;

`ifdef LC3_FETCH_INSTR_COUNT_EN
  logic [31:0] r_instr_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_instr_count <= '0;
    end else if (r_state == ISSUE && !stall && !br_taken) begin
      r_instr_count <= r_instr_count + 32'd1;
    end
  end

  assign instr_count = r_instr_count;
`endif

endmodule

// File: tb/tb_lc3_fetch.sv
module tb_lc3_fetch;

  localparam int          LATV [2] = '{1, 3};
  localparam logic [15:0] PCR  [2] = '{16'h3000, 16'hFFFF};

  logic        clock;
  logic        reset;
  logic        enable_fetch;
  logic        stall;
  logic        br_taken;
  logic [15:0] taddr;

  logic [1:0]        o_rd;
  logic [1:0]        o_en;
  logic [1:0][15:0]  o_addr;
  logic [1:0][15:0]  o_dout;
  logic [1:0][15:0]  o_npc;
  logic [1:0][15:0]  i_rdata;
`ifdef LC3_FETCH_INSTR_COUNT_EN
  logic [1:0][31:0]  o_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Instruction memory contents: two fixed words, a hash elsewhere.
  function automatic logic [15:0] memval(input logic [15:0] a);
    if (a == 16'h3000) return 16'h1021;
    if (a == 16'h3004) return 16'h5020;
    return {a[6:0], a[15:7]} ^ 16'hC3A5;
  endfunction

  lc3_fetch #(.PC_RESET(16'h3000), .MEM_LAT(1)) u_dut_a (
    .clock(clock), .reset(reset), .enable_fetch(enable_fetch), .stall(stall),
    .br_taken(br_taken), .taddr(taddr), .imem_rd(o_rd[0]), .imem_addr(o_addr[0]),
    .imem_rdata(i_rdata[0]),
`ifdef LC3_FETCH_INSTR_COUNT_EN
    .instr_count(o_cnt[0]),
`endif
    .enable_decode(o_en[0]), .dout(o_dout[0]), .npc_in(o_npc[0])
  );

  lc3_fetch #(.PC_RESET(16'hFFFF), .MEM_LAT(3)) u_dut_b (
    .clock(clock), .reset(reset), .enable_fetch(enable_fetch), .stall(stall),
    .br_taken(br_taken), .taddr(taddr), .imem_rd(o_rd[1]), .imem_addr(o_addr[1]),
    .imem_rdata(i_rdata[1]),
`ifdef LC3_FETCH_INSTR_COUNT_EN
    .instr_count(o_cnt[1]),
`endif
    .enable_decode(o_en[1]), .dout(o_dout[1]), .npc_in(o_npc[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memories with fixed latency; non-response cycles carry random junk.
  logic        a_pv = 1'b0;
  logic [15:0] a_pa = '0;
  logic [2:0]  b_pv = '0;
  logic [15:0] b_pa [3] = '{16'h0, 16'h0, 16'h0};
  logic [15:0] junk = '0;

  always @(posedge clock) begin
    a_pv    <= o_rd[0];
    a_pa    <= o_addr[0];
    b_pv    <= {b_pv[1:0], o_rd[1]};
    b_pa[0] <= o_addr[1];
    b_pa[1] <= b_pa[0];
    b_pa[2] <= b_pa[1];
    junk    <= 16'($urandom);
  end

  assign i_rdata[0] = a_pv    ? memval(a_pa)    : junk;
  assign i_rdata[1] = b_pv[2] ? memval(b_pa[2]) : junk;

  // Reference model: m_phase counts cycles since the request
  // (-1 = no fetch, 0 = request cycle, LAT+1 = word presented).
  int          m_phase [2];
  logic [15:0] m_pc    [2];
  logic [15:0] m_d     [2];
  logic [15:0] m_n     [2];
  logic [31:0] m_cnt   [2];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        m_phase[i] <= -1;
        m_pc[i]    <= PCR[i];
        m_d[i]     <= '0;
        m_n[i]     <= '0;
        m_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (br_taken) begin
          m_pc[i]    <= taddr;
          m_phase[i] <= enable_fetch ? 0 : -1;
        end else if (m_phase[i] == -1) begin
          if (enable_fetch) m_phase[i] <= 0;
        end else if (m_phase[i] < LATV[i]) begin
          m_phase[i] <= m_phase[i] + 1;
        end else if (m_phase[i] == LATV[i]) begin
          m_d[i]     <= memval(m_pc[i]);
          m_n[i]     <= m_pc[i] + 16'd1;
          m_phase[i] <= LATV[i] + 1;
        end else if (!stall) begin
          m_pc[i]    <= m_pc[i] + 16'd1;
          m_cnt[i]   <= m_cnt[i] + 32'd1;
          m_phase[i] <= enable_fetch ? 0 : -1;
        end
      end
    end
  end

  task automatic test_reset();
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      checks++; if (o_rd[i] !== 1'b0) begin errors++; $display("FAIL reset_rd[%0d]: got %b want 0", i, o_rd[i]); end
      checks++; if (o_en[i] !== 1'b0) begin errors++; $display("FAIL reset_en[%0d]: got %b want 0", i, o_en[i]); end
      checks++; if (o_dout[i] !== 16'h0000) begin errors++; $display("FAIL reset_dout[%0d]: got %h want 0000", i, o_dout[i]); end
      checks++; if (o_npc[i] !== 16'h0000) begin errors++; $display("FAIL reset_npc[%0d]: got %h want 0000", i, o_npc[i]); end
      checks++; if (o_addr[i] !== PCR[i]) begin errors++; $display("FAIL reset_addr[%0d]: got %h want %h", i, o_addr[i], PCR[i]); end
`ifdef LC3_FETCH_INSTR_COUNT_EN
      checks++; if (o_cnt[i] !== 32'd0) begin errors++; $display("FAIL reset_cnt[%0d]: got %0d want 0", i, o_cnt[i]); end
`endif
    end
  endtask

  task automatic test_first_fetch();
    enable_fetch = 1'b1;
    reset        = 1'b1;
    @(negedge clock); // cycle 0
    checks++; if (o_rd[0] !== 1'b1 || o_addr[0] !== 16'h3000) begin errors++; $display("FAIL first_req_a: got rd=%b addr=%h want rd=1 addr=3000", o_rd[0], o_addr[0]); end
    checks++; if (o_rd[1] !== 1'b1 || o_addr[1] !== 16'hFFFF) begin errors++; $display("FAIL first_req_b: got rd=%b addr=%h want rd=1 addr=ffff", o_rd[1], o_addr[1]); end
    @(negedge clock); // cycle 1
    checks++; if (o_rd[0] !== 1'b0 || o_en[0] !== 1'b0) begin errors++; $display("FAIL first_wait_a: got rd=%b en=%b want 0 0", o_rd[0], o_en[0]); end
    @(negedge clock); // cycle 2
    checks++; if (o_en[0] !== 1'b1 || o_dout[0] !== 16'h1021 || o_npc[0] !== 16'h3001) begin errors++; $display("FAIL first_issue_a: got en=%b dout=%h npc=%h want 1 1021 3001", o_en[0], o_dout[0], o_npc[0]); end
    @(negedge clock); // cycle 3
    checks++; if (o_rd[0] !== 1'b1 || o_addr[0] !== 16'h3001) begin errors++; $display("FAIL second_req_a: got rd=%b addr=%h want 1 3001", o_rd[0], o_addr[0]); end
    @(negedge clock); // cycle 4
    checks++; if (o_en[1] !== 1'b1 || o_dout[1] !== memval(16'hFFFF) || o_npc[1] !== 16'h0000) begin errors++; $display("FAIL wrap_issue_b: got en=%b dout=%h npc=%h want 1 %h 0000", o_en[1], o_dout[1], o_npc[1], memval(16'hFFFF)); end
    @(negedge clock); // cycle 5
    checks++; if (o_rd[1] !== 1'b1 || o_addr[1] !== 16'h0000) begin errors++; $display("FAIL wrap_req_b: got rd=%b addr=%h want 1 0000", o_rd[1], o_addr[1]); end
  endtask

  task automatic test_branch_wait();
    int k = 0;
    while (!(o_rd[0] === 1'b1 && o_addr[0] === 16'h3002) && k < 12) begin @(negedge clock); k++; end
    checks++; if (k >= 12) begin errors++; $display("FAIL wait_req_3002: got timeout want request for 3002"); end
    @(negedge clock); // WAIT for 3002
    checks++; if (o_rd[0] !== 1'b0 || o_en[0] !== 1'b0) begin errors++; $display("FAIL bw_in_wait: got rd=%b en=%b want 0 0", o_rd[0], o_en[0]); end
    br_taken = 1'b1;
    taddr    = 16'h4000;
    @(negedge clock);
    br_taken = 1'b0;
    checks++; if (o_rd[0] !== 1'b1 || o_addr[0] !== 16'h4000 || o_en[0] !== 1'b0) begin errors++; $display("FAIL bw_redirect: got rd=%b addr=%h en=%b want 1 4000 0", o_rd[0], o_addr[0], o_en[0]); end
    @(negedge clock);
    checks++; if (o_en[0] !== 1'b0) begin errors++; $display("FAIL bw_no_stale_issue: got en=%b dout=%h want en=0", o_en[0], o_dout[0]); end
    @(negedge clock);
    checks++; if (o_en[0] !== 1'b1 || o_dout[0] !== memval(16'h4000) || o_npc[0] !== 16'h4001) begin errors++; $display("FAIL bw_target_issue: got en=%b dout=%h npc=%h want 1 %h 4001", o_en[0], o_dout[0], o_npc[0], memval(16'h4000)); end
  endtask

  task automatic test_stall_hold();
    int k = 0;
    br_taken = 1'b1;
    taddr    = 16'h3004;
    @(negedge clock);
    br_taken = 1'b0;
    while (o_en[0] !== 1'b1 && k < 12) begin @(negedge clock); k++; end
    checks++; if (o_en[0] !== 1'b1 || o_dout[0] !== 16'h5020 || o_npc[0] !== 16'h3005) begin errors++; $display("FAIL stall_first: got en=%b dout=%h npc=%h want 1 5020 3005", o_en[0], o_dout[0], o_npc[0]); end
    stall = 1'b1;
    for (int c = 1; c < 4; c++) begin
      @(negedge clock);
      checks++; if (o_en[0] !== 1'b1 || o_dout[0] !== 16'h5020 || o_npc[0] !== 16'h3005 || o_rd[0] !== 1'b0) begin errors++; $display("FAIL stall_hold_c%0d: got en=%b dout=%h npc=%h rd=%b want 1 5020 3005 0", c, o_en[0], o_dout[0], o_npc[0], o_rd[0]); end
    end
    stall = 1'b0;
    @(negedge clock);
    checks++; if (o_rd[0] !== 1'b1 || o_addr[0] !== 16'h3005) begin errors++; $display("FAIL stall_release: got rd=%b addr=%h want 1 3005", o_rd[0], o_addr[0]); end
  endtask

  task automatic test_branch_stall();
    int k = 0;
    while (o_en[0] !== 1'b1 && k < 12) begin @(negedge clock); k++; end
    stall = 1'b1;
    @(negedge clock);
    checks++; if (o_en[0] !== 1'b1 || o_npc[0] !== 16'h3006) begin errors++; $display("FAIL bs_held: got en=%b npc=%h want 1 3006", o_en[0], o_npc[0]); end
    br_taken = 1'b1;
    taddr    = 16'h3100;
    @(negedge clock);
    br_taken = 1'b0;
    checks++; if (o_en[0] !== 1'b0 || o_rd[0] !== 1'b1 || o_addr[0] !== 16'h3100) begin errors++; $display("FAIL bs_redirect: got en=%b rd=%b addr=%h want 0 1 3100", o_en[0], o_rd[0], o_addr[0]); end
    k = 0;
    while (o_en[0] !== 1'b1 && k < 12) begin @(negedge clock); k++; end
    checks++; if (o_en[0] !== 1'b1 || o_dout[0] !== memval(16'h3100) || o_npc[0] !== 16'h3101) begin errors++; $display("FAIL bs_target_issue: got en=%b dout=%h npc=%h want 1 %h 3101", o_en[0], o_dout[0], o_npc[0], memval(16'h3100)); end
    stall = 1'b0;
    @(negedge clock);
    checks++; if (o_rd[0] !== 1'b1 || o_addr[0] !== 16'h3101) begin errors++; $display("FAIL bs_next_req: got rd=%b addr=%h want 1 3101", o_rd[0], o_addr[0]); end
  endtask

  task automatic test_lat3_drop();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (o_rd[i] !== 1'b0 || o_en[i] !== 1'b0 || o_dout[i] !== 16'h0 || o_npc[i] !== 16'h0 || o_addr[i] !== PCR[i]) begin errors++; $display("FAIL async_reset[%0d]: got rd=%b en=%b dout=%h npc=%h addr=%h want 0 0 0000 0000 %h", i, o_rd[i], o_en[i], o_dout[i], o_npc[i], o_addr[i], PCR[i]); end
    end
    @(negedge clock);
    reset        = 1'b1;
    enable_fetch = 1'b1;
    @(negedge clock); // cycle 0
    checks++; if (o_rd[1] !== 1'b1 || o_addr[1] !== 16'hFFFF) begin errors++; $display("FAIL l3_req: got rd=%b addr=%h want 1 ffff", o_rd[1], o_addr[1]); end
    enable_fetch = 1'b0;
    for (int c = 1; c < 4; c++) begin
      @(negedge clock);
      checks++; if (o_en[1] !== 1'b0 || o_rd[1] !== 1'b0) begin errors++; $display("FAIL l3_wait_c%0d: got en=%b rd=%b want 0 0", c, o_en[1], o_rd[1]); end
    end
    @(negedge clock); // cycle 4
    checks++; if (o_en[1] !== 1'b1 || o_dout[1] !== memval(16'hFFFF) || o_npc[1] !== 16'h0000) begin errors++; $display("FAIL l3_issue: got en=%b dout=%h npc=%h want 1 %h 0000", o_en[1], o_dout[1], o_npc[1], memval(16'hFFFF)); end
    for (int c = 5; c < 9; c++) begin
      @(negedge clock);
      checks++; if (o_en[1] !== 1'b0 || o_rd[1] !== 1'b0 || o_addr[1] !== 16'h0000) begin errors++; $display("FAIL l3_idle_c%0d: got en=%b rd=%b addr=%h want 0 0 0000", c, o_en[1], o_rd[1], o_addr[1]); end
    end
`ifdef LC3_FETCH_INSTR_COUNT_EN
    for (int i = 0; i < 2; i++) begin
      checks++; if (o_cnt[i] !== 32'd1) begin errors++; $display("FAIL l3_count[%0d]: got %0d want 1", i, o_cnt[i]); end
    end
`endif
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        checks++; if (o_rd[i] !== (m_phase[i] == 0)) begin errors++; $display("FAIL rnd_rd[%0d] c%0d: got %b want %b", i, c, o_rd[i], m_phase[i] == 0); end
        checks++; if (o_addr[i] !== m_pc[i]) begin errors++; $display("FAIL rnd_addr[%0d] c%0d: got %h want %h", i, c, o_addr[i], m_pc[i]); end
        checks++; if (o_en[i] !== (m_phase[i] == LATV[i] + 1)) begin errors++; $display("FAIL rnd_en[%0d] c%0d: got %b want %b", i, c, o_en[i], m_phase[i] == LATV[i] + 1); end
        if (m_phase[i] == LATV[i] + 1) begin
          checks++; if (o_dout[i] !== m_d[i] || o_npc[i] !== m_n[i]) begin errors++; $display("FAIL rnd_data[%0d] c%0d: got dout=%h npc=%h want %h %h", i, c, o_dout[i], o_npc[i], m_d[i], m_n[i]); end
        end
`ifdef LC3_FETCH_INSTR_COUNT_EN
        checks++; if (o_cnt[i] !== m_cnt[i]) begin errors++; $display("FAIL rnd_cnt[%0d] c%0d: got %0d want %0d", i, c, o_cnt[i], m_cnt[i]); end
`endif
      end
      enable_fetch = ($urandom_range(0, 3) != 0);
      stall        = ($urandom_range(0, 2) == 0);
      br_taken     = ($urandom_range(0, 15) == 0);
      taddr        = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3))
                                                 : 16'($urandom);
    end
    br_taken = 1'b0;
    stall    = 1'b0;
  endtask

  initial begin
    reset        = 1'b0;
    enable_fetch = 1'b0;
    stall        = 1'b0;
    br_taken     = 1'b0;
    taddr        = '0;
    test_reset();
    test_first_fetch();
    test_branch_wait();
    test_stall_hold();
    test_branch_stall();
    test_lat3_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lc3_fetch.md
Name: lc3_fetch

Overview:
- Fetch stage that drives the decode_in bus (enable_decode, dout, npc_in) consumed by the decode stage.
- Holds the PC and issues single-word reads to instruction memory, which returns data after a fixed latency.
- Presents each fetched instruction with its next-PC to decode, holds it under stall, and redirects on branch.
- Sits between instruction memory and the decode unit in the LC-3 pipeline.

Parameters:
- PC_RESET, 16'h3000, PC value loaded on reset.
- MEM_LAT, 1, instruction-memory read latency in cycles. Legal range 1..15.

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable_fetch  in  1  level; 1 permits new fetch requests.
- stall  in  1  decode backpressure; 1 holds the current issue.
- br_taken  in  1  1-cycle pulse; redirect PC to taddr.
- taddr  in  16  branch/jump target.
- imem_rd  out  1  instruction-memory read strobe, 1 cycle per fetch.
- imem_addr  out  16  read address, equal to pc.
- imem_rdata  in  16  read data, valid exactly MEM_LAT cycles after imem_rd.
- enable_decode  out  1  valid qualifier for dout/npc_in.
- dout  out  16  fetched instruction word.
- npc_in  out  16  address of dout + 1, modulo 2^16.

Behaviour:
- Reset (reset=0, async):
  - pc=PC_RESET, state=IDLE, lat_cnt=0.
  - enable_decode=0, dout=16'h0000, npc_in=16'h0000, imem_rd=0, imem_addr=PC_RESET.
- State machine, one state per cycle:
  - IDLE: imem_rd=0. Goes to REQ when enable_fetch=1.
  - REQ: imem_rd=1 and imem_addr=pc for this single cycle. Load lat_cnt=MEM_LAT. Go to WAIT.
  - WAIT: decrement lat_cnt. At the edge where lat_cnt==1, capture dout<=imem_rdata and npc_in<=pc+1, then go to ISSUE.
  - ISSUE: enable_decode=1 while in this state.
    - stall=1: remain in ISSUE; dout and npc_in stay constant.
    - stall=0: pc<=pc+1; go to REQ if enable_fetch=1, otherwise IDLE.
- Latency and throughput:
  - REQ to first enable_decode cycle is MEM_LAT+1 cycles.
  - With no stall, throughput is one instruction per MEM_LAT+2 cycles.
- Arithmetic: 16-bit unsigned add with wrap. pc=16'hFFFF gives npc_in=16'h0000 and next pc=16'h0000.
- Branch (br_taken=1), from any state:
  - pc<=taddr.
  - Any in-flight WAIT is abandoned; the imem_rdata returned for that request is ignored.
  - enable_decode drops to 0 on the next cycle.
  - Next state is REQ if enable_fetch=1, otherwise IDLE.
  - Branch has priority over stall and over WAIT completion.
  - Branch in IDLE only loads pc.
- enable_fetch=0 during WAIT: the in-flight fetch completes and issues normally, then the block goes to IDLE.
- enable_fetch has no effect while held in ISSUE by stall.
- imem_addr always equals pc.
- Asynchronous reset mid-operation: all state clears immediately. Any pending memory response is ignored, because the block reaches REQ no earlier than 1 cycle after reset release and takes data only from its own request.

Optional Feature:
- Macro: LC3_FETCH_INSTR_COUNT_EN.
- Defined:
  - Adds output port instr_count [31:0], reset to 0.
  - Increments by 1 on each ISSUE cycle where stall=0 and br_taken=0, i.e. each instruction accepted by decode.
  - Wraps at 2^32.
- Undefined: no port, no counter logic; all other behaviour identical.

Test Plan:
- Reset release with enable_fetch=1, MEM_LAT=1, memory[3000]=16'h1021:
  - imem_rd=1 with addr 3000 at cycle 0.
  - enable_decode=1 at cycle 2 with dout=1021, npc_in=3001.
  - Next REQ at cycle 3 with addr 3001.
- stall=1 for 4 cycles during ISSUE of 16'h5020 at 3004: enable_decode stays 1 and dout/npc_in stay 5020/3005 for 4 cycles; no imem_rd; on release the next addr is 3005.
- br_taken=1, taddr=16'h4000 during WAIT for 3002:
  - data for 3002 is never issued.
  - next imem_addr=4000; issued npc_in=4001.
- Branch while stalled in ISSUE, taddr=16'h3100: enable_decode=0 next cycle; next fetch addr 3100; stall ignored.
- PC_RESET=16'hFFFF: first issue has npc_in=0000; second fetch addr=0000.
- MEM_LAT=3, enable_fetch dropped during WAIT:
  - the instruction issues 4 cycles after REQ.
  - the block then sits in IDLE with imem_rd=0.
  - with the macro defined, instr_count=1 after decode accepts it.
